// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet constants and types shared by the GMII receive and transmit paths
package eth_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} rx_state_t;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [10:0] MIN_LEN     = 11'd64;
    localparam logic [10:0] MAX_LEN     = 11'd1518;
    localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;
    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [2:0]  MAX_PRE     = 3'd7;
    function automatic logic len_bad(input logic [10:0] n);
        return n < MIN_LEN || n > MAX_LEN;
    endfunction
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: one-byte CRC-32 step, data bits taken LSB first into an MSB-first register
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    input  logic        en,
    input  logic        init,
    output logic [31:0] crc_out
);
    logic [31:0] c;
    // Eight serial LFSR steps unrolled; init wins over en
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++)
            c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC_POLY : 32'h0);
        crc_out = init ? CRC_INIT : en ? c : crc_in;
    end
endmodule

// File: rtl/gmii_recv.sv
// gmii_recv: GMII frame receiver with header parse, FCS strip, CRC and length checks
module gmii_recv
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
    parameter bit          CHECK_MAC = 1'b1
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic [47:0] rx_src_mac,
    output logic [15:0] rx_type,
    output logic        frame_done,
    output logic        frame_good,
    output logic        crc_err,
    output logic        len_err,
    output logic        phy_err,
    output logic [10:0] frame_len,
    output logic [15:0] good_cnt
);
    rx_state_t state, state_nx;
    logic dv_q, pend, first_q, er_acc;
    logic [2:0] pre_cnt, fill;
    logic [3:0] hdr_cnt;
    logic [111:0] hdr, hdr_nx;
    logic [39:0] dly;
    logic [10:0] len_cnt;
    logic [31:0] crc_q, crc_d;
    logic in_frame, mac_ok, emit, fall, crc_e, len_e, good;

    assign hdr_nx   = {hdr[103:0], gmii_rxd};
    assign in_frame = state == HEADER || state == PAYLOAD;
    assign mac_ok   = !CHECK_MAC || hdr_nx[111:64] == LOCAL_MAC || hdr_nx[111:64] == BCAST_MAC;
    assign emit     = state == PAYLOAD && fill == 3'd5;
    assign fall     = state == PAYLOAD && !gmii_rx_dv;
    assign crc_e    = crc_q != CRC_RESIDUE;
    assign len_e    = len_bad(len_cnt) || fill != 3'd5;
    assign good     = !(crc_e || len_e || er_acc);

    crc32_d8 u_crc (
        .crc_in (crc_q),
        .data   (gmii_rxd),
        .en     (in_frame && gmii_rx_dv),
        .init   (!in_frame),
        .crc_out(crc_d)
    );

    // State register
    always_ff @(posedge sys_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state; a frame only starts on a fresh rx_dv rising edge
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = !gmii_rx_dv ? IDLE : dv_q ? DROP :
                                 gmii_rxd == PRE_BYTE ? PREAMBLE : gmii_rxd == SFD_BYTE ? HEADER : DROP;
            PREAMBLE: state_nx = !gmii_rx_dv ? IDLE : gmii_rxd == SFD_BYTE ? HEADER :
                                 (gmii_rxd == PRE_BYTE && pre_cnt != MAX_PRE) ? PREAMBLE : DROP;
            HEADER:   state_nx = !gmii_rx_dv ? IDLE : hdr_cnt != 4'd13 ? HEADER : mac_ok ? PAYLOAD : DROP;
            PAYLOAD:  state_nx = gmii_rx_dv ? PAYLOAD : IDLE;
            DROP:     state_nx = gmii_rx_dv ? DROP : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Frame bookkeeping: preamble/header counters, header capture, length, CRC, delay line
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            dv_q    <= 1'b1;
            pre_cnt <= 3'd0;
            hdr_cnt <= 4'd0;
            hdr     <= '0;
            len_cnt <= 11'd0;
            crc_q   <= CRC_INIT;
            er_acc  <= 1'b0;
            dly     <= '0;
            fill    <= 3'd0;
            first_q <= 1'b1;
            pend    <= 1'b0;
        end else begin
            dv_q    <= gmii_rx_dv;
            pre_cnt <= state == PREAMBLE ? pre_cnt + 3'd1 : 3'd1;
            hdr_cnt <= state == HEADER ? hdr_cnt + 4'd1 : 4'd0;
            hdr     <= state == HEADER ? hdr_nx : hdr;
            len_cnt <= !in_frame ? 11'd0 : (gmii_rx_dv && len_cnt != 11'h7FF) ? len_cnt + 11'd1 : len_cnt;
            crc_q   <= crc_d;
            er_acc  <= (state != IDLE && er_acc) || (gmii_rx_dv && gmii_rx_er);
            dly     <= (state == PAYLOAD && gmii_rx_dv) ? {dly[31:0], gmii_rxd} : dly;
            fill    <= (state == PAYLOAD && gmii_rx_dv) ? (emit ? fill : fill + 3'd1) : 3'd0;
            first_q <= state == PAYLOAD ? first_q && !emit : 1'b1;
            pend    <= fall;
        end
    end

    // Payload stream out of the delay line and end-of-frame status
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            rx_sop     <= 1'b0;
            rx_eop     <= 1'b0;
            rx_src_mac <= 48'd0;
            rx_type    <= 16'd0;
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            phy_err    <= 1'b0;
            frame_len  <= 11'd0;
            good_cnt   <= 16'd0;
        end else begin
            rx_valid   <= emit;
            rx_sop     <= emit && first_q;
            rx_eop     <= emit && !gmii_rx_dv;
            rx_data    <= emit ? dly[39:32] : rx_data;
            rx_src_mac <= (emit && first_q) ? hdr[63:16] : rx_src_mac;
            rx_type    <= (emit && first_q) ? hdr[15:0] : rx_type;
            frame_done <= pend;
            frame_len  <= fall ? len_cnt : frame_len;
            crc_err    <= fall ? crc_e : crc_err;
            len_err    <= fall ? len_e : len_err;
            phy_err    <= fall ? er_acc : phy_err;
            frame_good <= fall ? good : frame_good;
            good_cnt   <= good_cnt + {15'd0, fall && good};
        end
    end
endmodule
